// File: rtl/nand4_exhaustive_tester.sv
// Exhaustive tester for a 4-input NAND: walks abcd through 0000..1111 and checks e against ~&abcd.
// Latency: 16*HOLD_CYCLES edges from the accepted start to the rising edge of done; err_cnt is registered.
// Backpressure: none; start is only accepted in IDLE and is ignored while a run or its done cycle is active.
module nand4_exhaustive_tester #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       e,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_cnt,
   output logic [3:0] last_fail_vec
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   // Last value of the hold counter, i.e. the cycle on which e is sampled.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] vec_q, vec_d;
   logic [7:0] hold_q, hold_d;
   logic [4:0] err_cnt_q, err_cnt_d;
   logic [3:0] last_fail_vec_q, last_fail_vec_d;
   logic       pass_q, pass_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic       expected;
   logic       mismatch;
   logic [4:0] err_next;

   // The vector register feeds the gate directly; it is forced back to 0000 whenever a run ends.
   assign {a, b, c, d}  = vec_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_cnt       = err_cnt_q;
   assign last_fail_vec = last_fail_vec_q;

   // Next-state logic: start acceptance, hold counting, sampling/compare and run completion.
   always_comb begin
      state_d         = state_q;
      vec_d           = vec_q;
      hold_d          = hold_q;
      err_cnt_d       = err_cnt_q;
      last_fail_vec_d = last_fail_vec_q;
      pass_d          = pass_q;
      busy_d          = busy_q;
      done_d          = 1'b0;

      expected = ~(vec_q[3] & vec_q[2] & vec_q[1] & vec_q[0]);
      mismatch = (e != expected);
      err_next = mismatch ? (err_cnt_q + 5'd1) : err_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d         = S_RUN;
               vec_d           = 4'd0;
               hold_d          = 8'd0;
               err_cnt_d       = 5'd0;
               last_fail_vec_d = 4'd0;
               busy_d          = 1'b1;
            end
         end
         S_RUN: begin
            if (hold_q == HOLD_LAST) begin
               err_cnt_d = err_next;
               if (mismatch) begin
                  last_fail_vec_d = vec_q;
               end
               hold_d = 8'd0;
               if (vec_q != 4'hF) begin
                  vec_d = vec_q + 4'd1;
               end else begin
                  // Last vector sampled: pass reflects the count including this sample.
                  state_d = S_DONE;
                  vec_d   = 4'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_next == 5'd0);
               end
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            vec_d   = 4'd0;
            hold_d  = 8'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any run immediately without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         vec_q           <= 4'd0;
         hold_q          <= 8'd0;
         err_cnt_q       <= 5'd0;
         last_fail_vec_q <= 4'd0;
         pass_q          <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         vec_q           <= vec_d;
         hold_q          <= hold_d;
         err_cnt_q       <= err_cnt_d;
         last_fail_vec_q <= last_fail_vec_d;
         pass_q          <= pass_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
      end
   end

endmodule
